dsi_video_packer: RTL

DSI_VIDEO_PACKER -- requirements
Module: dsi_video_packer

---
 rtl/dsi_video_pkg.sv | 28 ++
 rtl/dsi_test_pattern_gen.sv | 60 ++++++
 rtl/dsi_video_packer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/dsi_video_pkg.sv
// dsi_video_pkg
//   Shared constants for the DSI video packer: RGB888 pixel width, beat
//   counter width, pattern select codes and the 8-entry colour-bar table.
package dsi_video_pkg;

  localparam int RGB_W  = 24;
  localparam int BEAT_W = 12;

  typedef logic [RGB_W-1:0] rgb_t;

  typedef enum logic [1:0] {
    PAT_BLACK = 2'd0,
    PAT_WHITE = 2'd1,
    PAT_BARS  = 2'd2,
    PAT_RAMP  = 2'd3
  } pat_sel_e;

  // Left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam rgb_t BAR_TABLE [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic rgb_t bar_colour(input logic [2:0] idx);
    return BAR_TABLE[idx];
  endfunction

endpackage

// File: rtl/dsi_test_pattern_gen.sv
// dsi_test_pattern_gen
//   Combinational test-pattern mux. Produces the two RGB888 pixels of one
//   beat from the beat index within the line and the latched pattern select.
// Ports:
//   beat  - beat index within the active line (0-based)
//   sel   - pattern select (black / white / colour bars / horizontal ramp)
//   pix0  - first pixel of the beat, {R,G,B}
//   pix1  - second pixel of the beat, {R,G,B}
module dsi_test_pattern_gen
  import dsi_video_pkg::*;
#(
  parameter int H_ACTIVE = 540
) (
  input  logic [BEAT_W-1:0] beat,
  input  pat_sel_e          sel,
  output rgb_t              pix0,
  output rgb_t              pix1
);

  localparam logic [BEAT_W+2:0] H_DIV   = (BEAT_W+3)'(H_ACTIVE);
  localparam logic [BEAT_W+2:0] BAR_MAX = (BEAT_W+3)'(7);

  logic [BEAT_W+2:0] beat_x8;
  logic [BEAT_W+2:0] bar_raw;
  logic [2:0]        bar_idx;

  // Eight equal-width bars across H_ACTIVE beats; overlong lines stay on
  // the last (black) bar instead of wrapping.
  assign beat_x8 = {beat, 3'b000};
  assign bar_raw = beat_x8 / H_DIV;
  assign bar_idx = (bar_raw > BAR_MAX) ? 3'd7 : bar_raw[2:0];

  always_comb begin
    pix0 = '0;
    pix1 = '0;
    unique case (sel)
      PAT_BLACK: begin
        pix0 = '0;
        pix1 = '0;
      end
      PAT_WHITE: begin
        pix0 = '1;
        pix1 = '1;
      end
      PAT_BARS: begin
        pix0 = bar_colour(bar_idx);
        pix1 = bar_colour(bar_idx);
      end
      PAT_RAMP: begin
        pix0 = {3{beat[6:0], 1'b0}};
        pix1 = {3{beat[6:0], 1'b1}};
      end
      default: begin
        pix0 = '0;
        pix1 = '0;
      end
    endcase
  end

endmodule

// File: rtl/dsi_video_packer.sv
// dsi_video_packer
//   Packs two-pixel-per-beat RGB video into 48-bit RGB888 beats for a DSI TX
//   controller, generates sync-edge pulses, optionally substitutes a test
//   pattern, and checks line/frame geometry.
// Ports:
//   clk, rst_n                  - pixel clock, synchronous active-low reset
//   i_hs, i_vs, i_valid         - input syncs and beat qualifier
//   i_r, i_g, i_b               - per-channel data, [7:0] pixel0, [15:8] pixel1
//   i_pattern_en, i_pattern_sel - test pattern control, latched at frame start
//   o_vs_start/o_vs_end         - one-cycle pulses on i_vs rise/fall
//   o_hs_start/o_hs_end         - one-cycle pulses on i_hs rise/fall
//   o_valid, o_data             - packed beat, 2 cycles after the input
//   o_frame_cnt                 - frames seen (wraps)
//   o_line_err_cnt              - lines with a wrong beat count (saturating)
//   o_line_err, o_frame_err     - sticky geometry error flags
module dsi_video_packer
  import dsi_video_pkg::*;
#(
  parameter int H_ACTIVE = 540,
  parameter int V_ACTIVE = 1920
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_valid,
  input  logic [15:0] i_r,
  input  logic [15:0] i_g,
  input  logic [15:0] i_b,
  input  logic        i_pattern_en,
  input  logic [1:0]  i_pattern_sel,
  output logic        o_vs_start,
  output logic        o_vs_end,
  output logic        o_hs_start,
  output logic        o_hs_end,
  output logic        o_valid,
  output logic [47:0] o_data,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_line_err_cnt,
  output logic        o_line_err,
  output logic        o_frame_err
);

  localparam logic [BEAT_W-1:0] H_CNT    = BEAT_W'(H_ACTIVE);
  localparam logic [BEAT_W-1:0] V_CNT    = BEAT_W'(V_ACTIVE);
  localparam logic [BEAT_W-1:0] CNT_MAX  = '1;
  localparam logic [BEAT_W-1:0] CNT_ONE  = BEAT_W'(1);

  // armed stays low for the first cycle after reset so the edge history is
  // loaded from the live inputs before any edge can be reported.
  logic armed;
  logic hs_q, vs_q, valid_q;
  logic hs_rise, hs_fall, vs_rise, vs_fall, valid_fall;

  logic [BEAT_W-1:0] beat_cnt, beat_nxt, beat_idx;
  logic [BEAT_W-1:0] line_cnt, line_nxt;
  logic              line_bad;
  logic              seen_vs;

  logic              pat_en_q;
  pat_sel_e          pat_sel_q;
  rgb_t              pix0, pix1;
  logic [47:0]       data_mux;

  logic              s1_vs_start, s1_vs_end, s1_hs_start, s1_hs_end, s1_valid;
  logic [47:0]       s1_data;

  always_comb begin
    hs_rise    = armed &  i_hs    & ~hs_q;
    hs_fall    = armed & ~i_hs    &  hs_q;
    vs_rise    = armed &  i_vs    & ~vs_q;
    vs_fall    = armed & ~i_vs    &  vs_q;
    valid_fall = armed & ~i_valid &  valid_q;
  end

  // A beat coinciding with the hs rise is beat 0 of the new line.
  always_comb begin
    beat_idx = hs_rise ? '0 : beat_cnt;
    beat_nxt = beat_cnt;
    if (hs_rise)
      beat_nxt = i_valid ? CNT_ONE : '0;
    else if (i_valid && (beat_cnt != CNT_MAX))
      beat_nxt = beat_cnt + CNT_ONE;
  end

  // line_nxt already includes a line ending this cycle, so a simultaneous
  // vs rise checks the frame against the completed line count.
  always_comb begin
    line_bad = valid_fall && (beat_cnt != H_CNT);
    line_nxt = line_cnt;
    if (valid_fall && (line_cnt != CNT_MAX))
      line_nxt = line_cnt + CNT_ONE;
  end

  dsi_test_pattern_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern (
    .beat (beat_idx),
    .sel  (pat_sel_q),
    .pix0 (pix0),
    .pix1 (pix1)
  );

  assign data_mux = pat_en_q ? {pix1, pix0}
                             : {i_r[15:8], i_g[15:8], i_b[15:8],
                                i_r[7:0],  i_g[7:0],  i_b[7:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed          <= 1'b0;
      hs_q           <= 1'b0;
      vs_q           <= 1'b0;
      valid_q        <= 1'b0;
      beat_cnt       <= '0;
      line_cnt       <= '0;
      seen_vs        <= 1'b0;
      pat_en_q       <= 1'b0;
      pat_sel_q      <= PAT_BLACK;
      s1_vs_start    <= 1'b0;
      s1_vs_end      <= 1'b0;
      s1_hs_start    <= 1'b0;
      s1_hs_end      <= 1'b0;
      s1_valid       <= 1'b0;
      s1_data        <= '0;
      o_vs_start     <= 1'b0;
      o_vs_end       <= 1'b0;
      o_hs_start     <= 1'b0;
      o_hs_end       <= 1'b0;
      o_valid        <= 1'b0;
      o_data         <= '0;
      o_frame_cnt    <= '0;
      o_line_err_cnt <= '0;
      o_line_err     <= 1'b0;
      o_frame_err    <= 1'b0;
    end else begin
      armed       <= 1'b1;
      hs_q        <= i_hs;
      vs_q        <= i_vs;
      valid_q     <= i_valid;

      s1_vs_start <= vs_rise;
      s1_vs_end   <= vs_fall;
      s1_hs_start <= hs_rise;
      s1_hs_end   <= hs_fall;
      s1_valid    <= i_valid;
      s1_data     <= data_mux;

      o_vs_start  <= s1_vs_start;
      o_vs_end    <= s1_vs_end;
      o_hs_start  <= s1_hs_start;
      o_hs_end    <= s1_hs_end;
      o_valid     <= s1_valid;
      o_data      <= s1_data;

      beat_cnt    <= beat_nxt;

      if (line_bad) begin
        o_line_err <= 1'b1;
        if (o_line_err_cnt != 16'hFFFF)
          o_line_err_cnt <= o_line_err_cnt + 16'd1;
      end

      if (vs_rise) begin
        o_frame_cnt <= o_frame_cnt + 16'd1;
        if (seen_vs && (line_nxt != V_CNT))
          o_frame_err <= 1'b1;
        line_cnt  <= '0;
        seen_vs   <= 1'b1;
        pat_en_q  <= i_pattern_en;
        pat_sel_q <= pat_sel_e'(i_pattern_sel);
      end else begin
        line_cnt <= line_nxt;
      end
    end
  end

endmodule
